flappy_referee: RTL and testbench

Game referee sitting directly downstream of the bird-physics/pillar-height block. It scrolls two pipes across the screen and latches each pipe's gap height from the upstream pillar outputs on every wrap. It checks the bird against the pipes and the ground, and runs the IDLE/PLAY/DEAD game FSM. It keeps a saturating 3-digit BCD score and drives pipe positions, score and state to the VGA renderer.

---
 rtl/flappy_pkg.sv | 26 ++
 rtl/bcd_counter3.sv | 52 +++++
 rtl/flappy_referee.sv | 163 ++++++++++++++++
 tb/tb_flappy_referee.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// ============================================================================
// Module   : flappy_pkg
// Brief    : Shared game-state encodings, screen constants and BCD digit type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package flappy_pkg;

  localparam int c_SCREEN_W = 640;
  localparam int c_SCREEN_H = 480;

  // Gaps restart at mid-screen so a fresh game is survivable before the first wrap.
  localparam logic [9:0] c_GAP_RESET = 10'(c_SCREEN_H / 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

`default_nettype wire

// File: rtl/bcd_counter3.sv
// ============================================================================
// Module   : bcd_counter3
// Brief    : Three-digit BCD up-counter with synchronous clear, saturating at 999.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_counter3
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] q
);

  bcd_digit_t [2:0] r_d;
  bcd_digit_t [2:0] w_d_nxt;

  always_comb begin
    w_d_nxt = r_d;
    if (r_d != 12'h999) begin
      if (r_d[0] == 4'd9) begin
        w_d_nxt[0] = 4'd0;
        if (r_d[1] == 4'd9) begin
          w_d_nxt[1] = 4'd0;
          w_d_nxt[2] = r_d[2] + 4'd1;
        end else begin
          w_d_nxt[1] = r_d[1] + 4'd1;
        end
      end else begin
        w_d_nxt[0] = r_d[0] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d <= '0;
    end else if (clr) begin
      r_d <= '0;
    end else if (inc) begin
      r_d <= w_d_nxt;
    end
  end

  assign q = r_d;

endmodule

`default_nettype wire

// File: rtl/flappy_referee.sv
// ============================================================================
// Module   : flappy_referee
// Brief    : Pipe scrolling, collision/score referee and IDLE/PLAY/DEAD game FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module flappy_referee
  import flappy_pkg::*;
#(
  parameter int SCREEN_W    = c_SCREEN_W,
  parameter int BIRD_X      = 160,
  parameter int BIRD_R      = 8,
  parameter int PIPE_W      = 40,
  parameter int GAP_H       = 120,
  parameter int SPEED       = 2,
  parameter int DEAD_FRAMES = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              flap,
  input  logic signed [9:0] bird_y,
  input  logic        [9:0] p1,
  input  logic        [9:0] p2,
  output logic        [1:0] state,
  output logic       [11:0] score,
  output logic        [9:0] pipe1_x,
  output logic        [9:0] pipe2_x,
  output logic        [9:0] gap1,
  output logic        [9:0] gap2,
  output logic              hit,
  output logic              game_rst
);

  localparam int                     c_CNT_W     = $clog2(DEAD_FRAMES);
  localparam logic [c_CNT_W-1:0]     c_DEAD_LAST = c_CNT_W'(DEAD_FRAMES - 1);
  localparam logic [9:0]             c_SPEED     = 10'(SPEED);
  localparam logic [9:0]             c_X_WRAP    = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0]             c_SCORE_X   = 10'(BIRD_X - BIRD_R);
  localparam logic signed [11:0]     c_OV_LO     = 12'(BIRD_X - BIRD_R);
  localparam logic signed [11:0]     c_OV_HI     = 12'(BIRD_X + BIRD_R + PIPE_W);
  localparam logic signed [11:0]     c_BR        = 12'(BIRD_R);
  localparam logic signed [11:0]     c_HALF_GAP  = 12'(GAP_H / 2);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_hit;
  logic                 r_game_rst;
  logic                 w_hit_nxt;
  logic                 w_game_rst_nxt;
  logic [c_CNT_W-1:0]   r_dead_cnt;
  logic [c_CNT_W-1:0]   w_dead_cnt_nxt;
  logic                 w_start;
  logic                 w_advance;
  logic                 w_collide;
  logic                 w_dead_last;
  logic signed [11:0]   w_y;
  logic [1:0][9:0]      w_x;
  logic [1:0][9:0]      w_gap;
  logic [1:0][9:0]      w_p;
  logic [1:0]           w_pipe_hit;
  logic [1:0]           w_cross;

  assign w_y = {{2{bird_y[9]}}, bird_y};
  assign w_p = {p2, p1};

  for (genvar i = 0; i < 2; i++) begin : g_pipe
    localparam logic [9:0] c_X_RESET = 10'(SCREEN_W + PIPE_W + i * (SCREEN_W / 2));

    logic [9:0]         r_x;
    logic [9:0]         r_gap;
    logic [9:0]         w_x_dec;
    logic signed [11:0] w_xs;
    logic signed [11:0] w_gs;

    assign w_xs    = {2'b00, r_x};
    assign w_gs    = {2'b00, r_gap};
    assign w_x_dec = r_x - c_SPEED;

    assign w_pipe_hit[i] = (w_xs > c_OV_LO) && (w_xs < c_OV_HI) &&
                           ((w_y - c_BR < w_gs - c_HALF_GAP) || (w_y + c_BR > w_gs + c_HALF_GAP));
    // A wrapping pipe jumps back to the right edge and never counts as a pass.
    assign w_cross[i] = (r_x > c_SPEED) && (r_x >= c_SCORE_X) && (w_x_dec < c_SCORE_X);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_x   <= c_X_RESET;
        r_gap <= c_GAP_RESET;
      end else if (w_start) begin
        r_x   <= c_X_RESET;
        r_gap <= c_GAP_RESET;
      end else if (w_advance) begin
        if (r_x <= c_SPEED) begin
          r_x   <= c_X_WRAP;
          r_gap <= w_p[i];
        end else begin
          r_x   <= w_x_dec;
        end
      end
    end

    assign w_x[i]   = r_x;
    assign w_gap[i] = r_gap;
  end

  assign w_collide   = (|w_pipe_hit) || (w_y <= 12'sd0);
  assign w_dead_last = (r_dead_cnt == c_DEAD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hit      <= 1'b0;
      r_game_rst <= 1'b0;
      r_dead_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hit      <= w_hit_nxt;
      r_game_rst <= w_game_rst_nxt;
      r_dead_cnt <= w_dead_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (flap) w_state_nxt = ST_PLAY;
      ST_PLAY: if (frame_tick && w_collide) w_state_nxt = ST_DEAD;
      ST_DEAD: if (frame_tick && w_dead_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start        = (r_state == ST_IDLE) && flap;
    w_advance      = (r_state == ST_PLAY) && frame_tick && !w_collide;
    w_hit_nxt      = (r_state == ST_PLAY) && frame_tick && w_collide;
    w_game_rst_nxt = (r_state == ST_DEAD) && frame_tick && w_dead_last;
    w_dead_cnt_nxt = r_dead_cnt;
    if ((r_state == ST_DEAD) && frame_tick) begin
      w_dead_cnt_nxt = w_dead_last ? '0 : r_dead_cnt + 1'b1;
    end
  end

  bcd_counter3 u_score (
    .clk (clk),
    .rst (rst),
    .clr (w_start),
    .inc (w_advance && (|w_cross)),
    .q   (score)
  );

  assign state    = r_state;
  assign pipe1_x  = w_x[0];
  assign pipe2_x  = w_x[1];
  assign gap1     = w_gap[0];
  assign gap2     = w_gap[1];
  assign hit      = r_hit;
  assign game_rst = r_game_rst;

endmodule

`default_nettype wire

// File: tb/tb_flappy_referee.sv
// ============================================================================
// Module   : tb_flappy_referee
// Brief    : Randomised and directed bench for flappy_referee against a game-rule model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_flappy_referee;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: default geometry. Index 1: shrunken geometry that reaches score saturation quickly.
  logic              tick     [2];
  logic              flap     [2];
  logic signed [9:0] y        [2];
  logic        [9:0] pa       [2];
  logic        [9:0] pb       [2];
  logic        [1:0] o_state  [2];
  logic       [11:0] o_score  [2];
  logic        [9:0] o_x1     [2];
  logic        [9:0] o_x2     [2];
  logic        [9:0] o_g1     [2];
  logic        [9:0] o_g2     [2];
  logic              o_hit    [2];
  logic              o_grst   [2];

  int g_sw [2] = '{640, 64};
  int g_bx [2] = '{160, 20};
  int g_br [2] = '{8, 2};
  int g_pw [2] = '{40, 8};
  int g_gh [2] = '{120, 120};
  int g_sp [2] = '{2, 8};
  int g_df [2] = '{60, 3};

  int m_st [2], m_score [2], m_cnt [2], m_hit [2], m_grst [2];
  int m_x  [2][2];
  int m_gap[2][2];
  int in_y [2];
  int in_p [2][2];

  int n_checks = 0;
  int n_fail   = 0;

  flappy_referee u_dut (
    .clk(clk), .rst(rst), .frame_tick(tick[0]), .flap(flap[0]), .bird_y(y[0]),
    .p1(pa[0]), .p2(pb[0]), .state(o_state[0]), .score(o_score[0]),
    .pipe1_x(o_x1[0]), .pipe2_x(o_x2[0]), .gap1(o_g1[0]), .gap2(o_g2[0]),
    .hit(o_hit[0]), .game_rst(o_grst[0])
  );

  flappy_referee #(
    .SCREEN_W(64), .BIRD_X(20), .BIRD_R(2), .PIPE_W(8),
    .GAP_H(120), .SPEED(8), .DEAD_FRAMES(3)
  ) u_fast (
    .clk(clk), .rst(rst), .frame_tick(tick[1]), .flap(flap[1]), .bird_y(y[1]),
    .p1(pa[1]), .p2(pb[1]), .state(o_state[1]), .score(o_score[1]),
    .pipe1_x(o_x1[1]), .pipe2_x(o_x2[1]), .gap1(o_g1[1]), .gap2(o_g2[1]),
    .hit(o_hit[1]), .game_rst(o_grst[1])
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset(input int d);
    m_st[d] = 0; m_score[d] = 0; m_cnt[d] = 0; m_hit[d] = 0; m_grst[d] = 0;
    m_x[d][0] = g_sw[d] + g_pw[d];
    m_x[d][1] = g_sw[d] + g_pw[d] + g_sw[d] / 2;
    m_gap[d][0] = 240; m_gap[d][1] = 240;
  endtask

  // Game rules applied to one clock edge, using the inputs the DUT sees at that edge.
  task automatic model_step(input int d);
    int collide, scored, post, lo;
    m_hit[d] = 0; m_grst[d] = 0;
    lo = g_bx[d] - g_br[d];
    if (m_st[d] == 0) begin
      if (flap[d]) begin
        model_reset(d);
        m_st[d] = 1;
      end
    end else if (m_st[d] == 1) begin
      if (tick[d]) begin
        collide = (in_y[d] <= 0) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
          if (m_x[d][i] > lo && m_x[d][i] < g_bx[d] + g_br[d] + g_pw[d] &&
              (in_y[d] - g_br[d] < m_gap[d][i] - g_gh[d] / 2 ||
               in_y[d] + g_br[d] > m_gap[d][i] + g_gh[d] / 2))
            collide = 1;
        end
        if (collide != 0) begin
          m_st[d] = 2; m_hit[d] = 1;
        end else begin
          scored = 0;
          for (int i = 0; i < 2; i++) begin
            if (m_x[d][i] <= g_sp[d]) begin
              m_x[d][i] = g_sw[d] + g_pw[d];
              m_gap[d][i] = in_p[d][i];
            end else begin
              post = m_x[d][i] - g_sp[d];
              if (m_x[d][i] >= lo && post < lo) scored = 1;
              m_x[d][i] = post;
            end
          end
          if (scored != 0 && m_score[d] < 999) m_score[d]++;
        end
      end
    end else begin
      if (tick[d]) begin
        if (m_cnt[d] == g_df[d] - 1) begin
          m_st[d] = 0; m_grst[d] = 1; m_cnt[d] = 0;
        end else begin
          m_cnt[d]++;
        end
      end
    end
  endtask

  task automatic compare(input int d);
    check_value($sformatf("d%0d_state", d),   32'(o_state[d]), m_st[d]);
    check_value($sformatf("d%0d_score", d),   32'(o_score[d]), to_bcd(m_score[d]));
    check_value($sformatf("d%0d_pipe1_x", d), 32'(o_x1[d]),    m_x[d][0]);
    check_value($sformatf("d%0d_pipe2_x", d), 32'(o_x2[d]),    m_x[d][1]);
    check_value($sformatf("d%0d_gap1", d),    32'(o_g1[d]),    m_gap[d][0]);
    check_value($sformatf("d%0d_gap2", d),    32'(o_g2[d]),    m_gap[d][1]);
    check_value($sformatf("d%0d_hit", d),     32'(o_hit[d]),   m_hit[d]);
    check_value($sformatf("d%0d_game_rst", d), 32'(o_grst[d]), m_grst[d]);
  endtask

  task automatic drive(input int d, input logic t, input logic f, input int yv, input int a, input int b);
    tick[d] = t; flap[d] = f;
    in_y[d] = yv; in_p[d][0] = a; in_p[d][1] = b;
    y[d] = 10'(yv); pa[d] = 10'(a); pb[d] = 10'(b);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
  endtask

  initial begin
    int r, yv;
    drive(0, 0, 0, 240, 240, 240);
    drive(1, 0, 0, 240, 240, 240);
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    compare(0);
    compare(1);
    check_value("rst_pipe2_x", 32'(o_x2[0]), 1000);
    rst = 1'b0;

    // Start a game, then scroll pipe 1 through a full pass and wrap.
    drive(0, 0, 1, 240, 240, 240);
    cycle();
    check_value("start_state", 32'(o_state[0]), 1);
    check_value("start_pipe1_x", 32'(o_x1[0]), 680);
    for (int k = 1; k <= 340; k++) begin
      drive(0, 1, 0, 240, 240, 240);
      cycle();
      if (k == 265) check_value("first_score", 32'(o_score[0]), 32'h001);
      if (k == 340) check_value("wrap_pipe1_x", 32'(o_x1[0]), 680);
      drive(0, 0, 0, 240, 240, 240);
      cycle();
    end

    // Bring pipe 1 to x=170, then drop the bird below the gap.
    for (int k = 0; k < 255; k++) begin
      drive(0, 1, 0, 240, 240, 240);
      cycle();
    end
    drive(0, 1, 0, 100, 240, 240);
    cycle();
    check_value("hit_pulse", 32'(o_hit[0]), 1);
    check_value("hit_state", 32'(o_state[0]), 2);
    check_value("hit_pipe1_frozen", 32'(o_x1[0]), 170);
    check_value("hit_score", 32'(o_score[0]), 32'h002);
    drive(0, 0, 0, 100, 240, 240);
    cycle();
    check_value("hit_one_cycle", 32'(o_hit[0]), 0);

    // DEAD lasts exactly 60 ticks even with flap held.
    for (int k = 1; k <= 60; k++) begin
      drive(0, 1, 1, 240, 240, 240);
      cycle();
      check_value("dead_state", 32'(o_state[0]), (k < 60) ? 2 : 0);
      check_value("dead_game_rst", 32'(o_grst[0]), (k == 60) ? 1 : 0);
      drive(0, 0, (k < 60) ? 1'b1 : 1'b0, 240, 240, 240);
      cycle();
    end
    check_value("game_rst_one_cycle", 32'(o_grst[0]), 0);

    // Asynchronous reset in the middle of a game.
    drive(0, 0, 1, 240, 240, 240);
    cycle();
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, 240, 240, 240);
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    compare(0);
    compare(1);
    check_value("async_rst_pipe1_x", 32'(o_x1[0]), 680);
    #1 rst = 1'b0;

    // Ground contact with pipes far away.
    drive(0, 0, 1, 240, 240, 240);
    cycle();
    drive(0, 1, 0, 0, 240, 240);
    cycle();
    check_value("ground_hit", 32'(o_hit[0]), 1);
    check_value("ground_state", 32'(o_state[0]), 2);

    // Random play: occasional flaps, bird mostly near the gaps, some ground hits and wild heights.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)       yv = 0;
      else if (r < 10) yv = int'($urandom_range(0, 550)) - 50;
      else             yv = 220 + int'($urandom_range(0, 40));
      drive(0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), yv,
            200 + int'($urandom_range(0, 80)), 200 + int'($urandom_range(0, 80)));
      cycle();
    end
    drive(0, 0, 0, 240, 240, 240);

    // Shrunken geometry scores twice every 9 ticks; run well past 999.
    drive(1, 0, 1, 240, 240, 240);
    cycle();
    for (int n = 0; n < 4700; n++) begin
      drive(1, 1, 0, 240, 240, 240);
      cycle();
    end
    check_value("score_saturated", 32'(o_score[1]), 32'h999);
    check_value("saturated_state", 32'(o_state[1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
